// File: rtl/pmod_buttons_pkg.sv
// pmod_buttons_pkg
//   Constants and the pin map for the PMOD button reader.
//   Button 2k is on pmod[k] and button 2k+1 is on pmod[k+4]. The PMOD LED
//   driver uses the same map, so a button board and an LED board can be
//   swapped on a port.
package pmod_buttons_pkg;

   localparam int NUM_BTNS = 8;

   // Returns the connector pin that carries a given button bit.
   function automatic int btn_to_pin(input int btn);
      return (btn % 2 == 1) ? (4 + btn / 2) : (btn / 2);
   endfunction

endpackage

// File: rtl/pmod_debounce.sv
// pmod_debounce
//   One button bit: two-flop synchronizer, debounce counter, and registered
//   level with one-cycle rise/fall strobes.
//   Ports: clk, rst (sync, active high), din (raw level, 1 = pressed),
//          level (debounced level), rise / fall (one-cycle strobes on an
//          accepted 0->1 / 1->0 change).
module pmod_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_s1;
   logic             r_s2;
   logic             r_stable;
   logic [CNT_W-1:0] r_cnt;
   logic             r_rise;
   logic             r_fall;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1     <= 1'b0;
         r_s2     <= 1'b0;
         r_stable <= 1'b0;
         r_cnt    <= '0;
         r_rise   <= 1'b0;
         r_fall   <= 1'b0;
      end else begin
         r_s1   <= din;
         r_s2   <= r_s1;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
         if (r_s2 == r_stable) begin
            // Any agreement ends a mismatch run, so short glitches are dropped.
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_stable <= r_s2;
            r_cnt    <= '0;
            r_rise   <= r_s2;
            r_fall   <= ~r_s2;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign level = r_stable;
   assign rise  = r_rise;
   assign fall  = r_fall;

endmodule

// File: rtl/tristate_buffer.sv
// tristate_buffer
//   One bidirectional pad: drives pin with dout while oe is high, otherwise
//   leaves it floating. The pin level is always returned on di.
//   Ports: pin (inout pad), oe (output enable), dout (value to drive),
//          di (pin level as seen by the fabric).
module tristate_buffer (
   inout  wire  pin,
   input  logic oe,
   input  logic dout,
   output logic di
);

   assign pin = oe ? dout : 1'bz;
   assign di  = pin;

endmodule

// File: rtl/pmod_buttons.sv
// pmod_buttons
//   Reads eight buttons on a PMOD connector and presents debounced levels plus
//   one-cycle press/release strobes. The pins are never driven.
//   Parameters: DEBOUNCE_CYCLES (cycles a change must persist, >= 1),
//               ACTIVE_LOW (1: pressed button pulls the pin low).
//   Ports: clk, rst (sync, active high), pmod[7:0] (connector pins),
//          buttons (debounced level, 1 = pressed), pressed / released
//          (one-cycle strobes per bit).
module pmod_buttons
   import pmod_buttons_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int ACTIVE_LOW      = 1
) (
   input  logic                clk,
   input  logic                rst,
   inout  wire  [NUM_BTNS-1:0] pmod,
   output logic [NUM_BTNS-1:0] buttons,
   output logic [NUM_BTNS-1:0] pressed,
   output logic [NUM_BTNS-1:0] released
);

   localparam logic POL = (ACTIVE_LOW != 0);

   logic [NUM_BTNS-1:0] w_pin;
   logic [NUM_BTNS-1:0] w_btn;

   for (genvar k = 0; k < NUM_BTNS; k++) begin : g_pad
      tristate_buffer u_buf (
         .pin  (pmod[k]),
         .oe   (1'b0),
         .dout (1'b0),
         .di   (w_pin[k])
      );
   end

   // Remap pins to button order and normalise to 1 = pressed before the
   // synchronizer, so everything downstream is polarity-agnostic.
   for (genvar b = 0; b < NUM_BTNS; b++) begin : g_btn
      localparam int PIN = btn_to_pin(b);

      assign w_btn[b] = w_pin[PIN] ^ POL;

      pmod_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_deb (
         .clk   (clk),
         .rst   (rst),
         .din   (w_btn[b]),
         .level (buttons[b]),
         .rise  (pressed[b]),
         .fall  (released[b])
      );
   end

endmodule

// File: tb/tb_pmod_buttons.sv
module tb_pmod_buttons;

   localparam int DC = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] drv = 8'hFF;
   wire  [7:0] pmod;
   logic [7:0] buttons, pressed, released;

   assign pmod = drv;

   pmod_buttons #(.DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1)) dut (
      .clk      (clk),
      .rst      (rst),
      .pmod     (pmod),
      .buttons  (buttons),
      .pressed  (pressed),
      .released (released)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errs   = 0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a button level flips once the pin has shown the
   // opposite value for DC consecutive samples, seen through a two-sample
   // synchronizer delay. hist[i] is the pressed-sense sample taken i+1 edges ago.
   logic [7:0] hist [0:DC];
   logic [7:0] m_lvl = 8'h00, m_pr = 8'h00, m_rl = 8'h00;
   logic [7:0] smp;
   logic       all_diff;
   int         cyc = 0;

   initial for (int i = 0; i <= DC; i++) hist[i] = 8'h00;

   always @(posedge clk) begin
      // button 2k on pin k, button 2k+1 on pin k+4; pulled low = pressed
      for (int k = 0; k < 4; k++) begin
         smp[2*k]   = ~drv[k];
         smp[2*k+1] = ~drv[k+4];
      end
      m_pr = 8'h00;
      m_rl = 8'h00;
      if (rst) begin
         m_lvl = 8'h00;
         for (int i = 0; i <= DC; i++) hist[i] = 8'h00;
      end else begin
         for (int b = 0; b < 8; b++) begin
            all_diff = 1'b1;
            for (int i = 1; i <= DC; i++)
               if (hist[i][b] == m_lvl[b]) all_diff = 1'b0;
            if (all_diff) begin
               m_lvl[b] = ~m_lvl[b];
               m_pr[b]  = m_lvl[b];
               m_rl[b]  = ~m_lvl[b];
            end
         end
         for (int i = DC; i >= 1; i--) hist[i] = hist[i-1];
         hist[0] = smp;
      end
      cyc++;
   end

   always @(negedge clk) begin
      if (cyc > 0) begin
         chk("model_buttons", buttons, m_lvl);
         chk("model_pressed", pressed, m_pr);
         chk("model_released", released, m_rl);
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic settle();
      drv = 8'hFF;
      step(10);
   endtask

   initial begin
      step(3);
      chk("reset_buttons", buttons, 8'h00);
      chk("reset_pressed", pressed, 8'h00);
      chk("reset_released", released, 8'h00);
      rst = 1'b0;
      step(8);
      chk("idle_buttons", buttons, 8'h00);

      // press on pmod[0]
      drv = 8'hFE;
      step(5);
      chk("press_before", buttons, 8'h00);
      step(1);
      chk("press_buttons", buttons, 8'h01);
      chk("press_strobe", pressed, 8'h01);
      chk("press_no_release", released, 8'h00);
      step(1);
      chk("press_strobe_end", pressed, 8'h00);
      chk("press_held", buttons, 8'h01);

      // release
      drv = 8'hFF;
      step(5);
      chk("release_before", buttons, 8'h01);
      step(1);
      chk("release_buttons", buttons, 8'h00);
      chk("release_strobe", released, 8'h01);
      step(1);
      chk("release_strobe_end", released, 8'h00);
      step(4);

      // glitch of DC-1 cycles
      drv = 8'hFE;
      step(3);
      drv = 8'hFF;
      for (int i = 0; i < 10; i++) begin
         step(1);
         chk("glitch_buttons", buttons, 8'h00);
         chk("glitch_pressed", pressed, 8'h00);
      end

      // mapping
      drv = 8'hEF; step(6);
      chk("map_pin4", buttons, 8'h02);
      chk("map_pin4_strobe", pressed, 8'h02);
      settle();
      drv = 8'h7F; step(6);
      chk("map_pin7", buttons, 8'h80);
      settle();
      drv = 8'hF7; step(6);
      chk("map_pin3", buttons, 8'h40);
      settle();

      // all pins together
      drv = 8'h00; step(6);
      chk("all_buttons", buttons, 8'hFF);
      chk("all_pressed", pressed, 8'hFF);
      drv = 8'hFF; step(6);
      chk("all_released", released, 8'hFF);
      chk("all_off", buttons, 8'h00);
      step(4);

      // reset while pmod[2] is mid-count (cnt = 2 after edge 4)
      drv = 8'hFB;
      step(4);
      rst = 1'b1;
      step(1);
      chk("rst_mid_buttons", buttons, 8'h00);
      chk("rst_mid_pressed", pressed, 8'h00);
      rst = 1'b0;
      step(5);
      chk("rst_after_before", buttons, 8'h00);
      chk("rst_after_nostrobe", pressed, 8'h00);
      step(1);
      chk("rst_after_buttons", buttons, 8'h10);
      chk("rst_after_pressed", pressed, 8'h10);
      settle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
